// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared types and constants for the RGB-to-YUV encoder: FSM states,
// BT.601 coefficients scaled by 2^16, the rounding term and the output offsets.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [2:0] {
    S_ENC_IDLE,
    S_ENC_READ,
    S_ENC_WAIT,
    S_ENC_CALC,
    S_ENC_WRITE,
    S_ENC_DONE
  } enc_state_e;

  localparam logic [17:0] Y_BASE_DEF     = 18'd0;
  localparam logic [17:0] U_BASE_DEF     = 18'd38400;
  localparam logic [17:0] V_BASE_DEF     = 18'd57600;
  localparam logic [17:0] RGB_BASE_DEF   = 18'd146944;
  localparam int          NUM_PIXELS_DEF = 76800;

  localparam logic signed [31:0] C_Y_R =  32'sd16843;
  localparam logic signed [31:0] C_Y_G =  32'sd33030;
  localparam logic signed [31:0] C_Y_B =  32'sd6423;
  localparam logic signed [31:0] C_U_R = -32'sd9699;
  localparam logic signed [31:0] C_U_G = -32'sd19071;
  localparam logic signed [31:0] C_U_B =  32'sd28770;
  localparam logic signed [31:0] C_V_R =  32'sd28770;
  localparam logic signed [31:0] C_V_G = -32'sd24117;
  localparam logic signed [31:0] C_V_B = -32'sd4653;

  localparam logic signed [31:0] ROUND_K   = 32'sd32768;
  localparam logic signed [31:0] Y_OFFSET  = 32'sd16;
  localparam logic signed [31:0] UV_OFFSET = 32'sd128;

endpackage

// File: rtl/rgb_to_yuv_encoder_if.sv
// SRAM master bus plus the arbiter Enable/Done handshake of the encoder.
interface rgb_to_yuv_encoder_if;
  logic        Enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Done;

  modport master (
    input  Enable, SRAM_read_data,
    output SRAM_address, SRAM_write_data, SRAM_we_n, Done
  );

  modport slave (
    output Enable, SRAM_read_data,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, Done
  );
endinterface

// File: rtl/rgb_to_yuv_encoder_yuv_mac.sv
// Combinational three-term multiply-accumulate: rounds, shifts by 16,
// adds the plane offset and clips the result to 8 bits.
module yuv_mac
  import rgb_to_yuv_encoder_pkg::*;
(
  input  logic        [7:0]  op_a_i,
  input  logic        [7:0]  op_b_i,
  input  logic        [7:0]  op_c_i,
  input  logic signed [31:0] coef_a_i,
  input  logic signed [31:0] coef_b_i,
  input  logic signed [31:0] coef_c_i,
  input  logic signed [31:0] offset_i,
  output logic        [7:0]  res_o
);
  logic signed [31:0] sum;
  logic signed [31:0] val;

  always_comb begin
    sum = $signed({24'd0, op_a_i}) * coef_a_i
        + $signed({24'd0, op_b_i}) * coef_b_i
        + $signed({24'd0, op_c_i}) * coef_c_i
        + ROUND_K;
    val = (sum >>> 16) + offset_i;
    if (val < 32'sd0)
      res_o = 8'd0;
    else if (val > 32'sd255)
      res_o = 8'hFF;
    else
      res_o = val[7:0];
  end
endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Encodes packed RGB pixels from SRAM into planar Y and 2:1 subsampled U/V,
// four pixels per 24-cycle group on a single shared MAC.
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter logic [17:0] Y_BASE     = Y_BASE_DEF,
  parameter logic [17:0] U_BASE     = U_BASE_DEF,
  parameter logic [17:0] V_BASE     = V_BASE_DEF,
  parameter logic [17:0] RGB_BASE   = RGB_BASE_DEF,
  parameter int          NUM_PIXELS = NUM_PIXELS_DEF
) (
  input logic                  Clock,
  input logic                  Resetn,
  rgb_to_yuv_encoder_if.master bus
);
  localparam logic [15:0] LAST_GROUP = 16'(NUM_PIXELS / 4 - 1);

  enc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] g_q, g_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic        done_q, done_d;
  logic        rd_vld_q;
  logic [2:0]  rd_idx_q;

  logic [15:0] rgb_buf_q [6];
  logic [7:0]  y_q [4];
  logic [7:0]  u_q [4];
  logic [7:0]  v_q [4];
  logic [7:0]  pix_r [4];
  logic [7:0]  pix_g [4];
  logic [7:0]  pix_b [4];
  logic [7:0]  u_ds [2];
  logic [7:0]  v_ds [2];

  logic [1:0]         calc_pix, calc_phase;
  logic signed [31:0] coef_a, coef_b, coef_c, offs;
  logic [7:0]         mac_res;

  // Each pixel pair occupies three words; the upper byte is the earlier pixel.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pair
    assign pix_r[2*gi]   = rgb_buf_q[3*gi][15:8];
    assign pix_g[2*gi]   = rgb_buf_q[3*gi][7:0];
    assign pix_b[2*gi]   = rgb_buf_q[3*gi+1][15:8];
    assign pix_r[2*gi+1] = rgb_buf_q[3*gi+1][7:0];
    assign pix_g[2*gi+1] = rgb_buf_q[3*gi+2][15:8];
    assign pix_b[2*gi+1] = rgb_buf_q[3*gi+2][7:0];
    assign u_ds[gi] = 8'((9'(u_q[2*gi]) + 9'(u_q[2*gi+1]) + 9'd1) >> 1);
    assign v_ds[gi] = 8'((9'(v_q[2*gi]) + 9'(v_q[2*gi+1]) + 9'd1) >> 1);
  end

  assign calc_pix   = 2'(cnt_q / 4'd3);
  assign calc_phase = 2'(cnt_q % 4'd3);

  always_comb begin
    coef_a = C_Y_R;
    coef_b = C_Y_G;
    coef_c = C_Y_B;
    offs   = Y_OFFSET;
    case (calc_phase)
      2'd1: begin coef_a = C_U_R; coef_b = C_U_G; coef_c = C_U_B; offs = UV_OFFSET; end
      2'd2: begin coef_a = C_V_R; coef_b = C_V_G; coef_c = C_V_B; offs = UV_OFFSET; end
      default: ;
    endcase
  end

  yuv_mac u_mac (
    .op_a_i  (pix_r[calc_pix]),
    .op_b_i  (pix_g[calc_pix]),
    .op_c_i  (pix_b[calc_pix]),
    .coef_a_i(coef_a),
    .coef_b_i(coef_b),
    .coef_c_i(coef_c),
    .offset_i(offs),
    .res_o   (mac_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      S_ENC_IDLE: begin
        if (bus.Enable) begin
          state_d = S_ENC_READ;
          cnt_d   = 4'd0;
          g_d     = 16'd0;
          addr_d  = RGB_BASE;
        end
      end
      S_ENC_READ: begin
        if (cnt_q == 4'd5) begin
          state_d = S_ENC_WAIT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          addr_d = addr_q + 18'd1;
        end
      end
      S_ENC_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ENC_CALC;
          cnt_d   = 4'd0;
        end
      end
      S_ENC_CALC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          state_d = S_ENC_WRITE;
          cnt_d   = 4'd0;
          addr_d  = Y_BASE + 18'({g_q, 1'b0});
          wdata_d = {y_q[0], y_q[1]};
          we_n_d  = 1'b0;
        end
      end
      S_ENC_WRITE: begin
        cnt_d  = cnt_q + 4'd1;
        we_n_d = 1'b0;
        case (cnt_q)
          4'd0: begin addr_d = Y_BASE + 18'({g_q, 1'b1}); wdata_d = {y_q[2], y_q[3]}; end
          4'd1: begin addr_d = U_BASE + 18'(g_q);         wdata_d = {u_ds[0], u_ds[1]}; end
          4'd2: begin addr_d = V_BASE + 18'(g_q);         wdata_d = {v_ds[0], v_ds[1]}; end
          default: begin
            we_n_d = 1'b1;
            cnt_d  = 4'd0;
            if (g_q == LAST_GROUP) begin
              state_d = S_ENC_DONE;
            end else begin
              g_d     = g_q + 16'd1;
              state_d = S_ENC_READ;
              addr_d  = RGB_BASE + 18'({2'b00, g_d} * 18'd6);
            end
          end
        endcase
      end
      S_ENC_DONE: begin
        state_d = S_ENC_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_ENC_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_ENC_IDLE;
      cnt_q    <= 4'd0;
      g_q      <= 16'd0;
      addr_q   <= 18'd0;
      wdata_q  <= 16'd0;
      we_n_q   <= 1'b1;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      g_q      <= g_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_n_q   <= we_n_d;
      done_q   <= done_d;
      rd_vld_q <= (state_q == S_ENC_READ);
      rd_idx_q <= cnt_q[2:0];
    end
  end

  // Read data returns the cycle after the SRAM latches the address.
  always_ff @(posedge Clock) begin
    if (rd_vld_q)
      rgb_buf_q[rd_idx_q] <= bus.SRAM_read_data;
    if (state_q == S_ENC_CALC) begin
      case (calc_phase)
        2'd0:    y_q[calc_pix] <= mac_res;
        2'd1:    u_q[calc_pix] <= mac_res;
        default: v_q[calc_pix] <= mac_res;
      endcase
    end
  end

  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = wdata_q;
  assign bus.SRAM_we_n       = we_n_q;
  assign bus.Done            = done_q;
endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Directed checks of the RGB-to-YUV encoder using three instances sized for
// 4, 8 and 64 pixels sharing one behavioural SRAM.
module tb_rgb_to_yuv_encoder;
  localparam logic [17:0] RGB_B = 18'd146944;
  localparam logic [17:0] U_B   = 18'd38400;
  localparam logic [17:0] V_B   = 18'd57600;

  logic        Clock  = 1'b0;
  logic        Resetn = 1'b0;
  logic        en      [3];
  logic [17:0] s_addr  [3];
  logic [15:0] s_wdata [3];
  logic [15:0] s_rdata [3];
  logic        s_we_n  [3];
  logic        s_done  [3];
  logic [15:0] rmem [0:262143];
  logic [33:0] wlog [0:127];
  int          wr_cnt;
  logic        log_clr = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 Clock = ~Clock;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NP = (gi == 0) ? 4 : (gi == 1) ? 8 : 64;
    rgb_to_yuv_encoder_if bus ();
    rgb_to_yuv_encoder #(.NUM_PIXELS(NP)) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .bus   (bus)
    );
    assign bus.Enable         = en[gi];
    assign bus.SRAM_read_data = s_rdata[gi];
    assign s_addr[gi]         = bus.SRAM_address;
    assign s_wdata[gi]        = bus.SRAM_write_data;
    assign s_we_n[gi]         = bus.SRAM_we_n;
    assign s_done[gi]         = bus.Done;
  end

  // SRAM: address latched on one edge, data visible until the next.
  always @(posedge Clock) begin
    for (int i = 0; i < 3; i++) s_rdata[i] <= rmem[s_addr[i]];
    if (log_clr) wr_cnt <= 0;
    else
      for (int i = 0; i < 3; i++)
        if (s_we_n[i] === 1'b0 && wr_cnt < 128) begin
          wlog[wr_cnt] <= {s_addr[i], s_wdata[i]};
          wr_cnt       <= wr_cnt + 1;
        end
  end

  function automatic logic [7:0] ref_conv(input int r, input int g, input int b, input int kind);
    longint s;
    case (kind)
      0:       s = 64'sd16843 * r + 64'sd33030 * g + 64'sd6423 * b;
      1:       s = -64'sd9699 * r - 64'sd19071 * g + 64'sd28770 * b;
      default: s = 64'sd28770 * r - 64'sd24117 * g - 64'sd4653 * b;
    endcase
    s = ((s + 64'sd32768) >>> 16) + ((kind == 0) ? 64'sd16 : 64'sd128);
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  task automatic run_enc(input int idx, input int pulse, input int probe,
                         output int cyc, output logic [17:0] probe_addr);
    probe_addr = 18'h3FFFF;
    @(negedge Clock); log_clr = 1'b1;
    @(negedge Clock); log_clr = 1'b0; en[idx] = 1'b1;
    @(posedge Clock); #1; en[idx] = 1'b0;
    if (probe == 0) probe_addr = s_addr[idx];
    cyc = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge Clock); #1;
      if (c == probe) probe_addr = s_addr[idx];
      if (s_done[idx] === 1'b1) begin cyc = c; break; end
      en[idx] = (c == pulse || c == pulse + 19);
    end
    en[idx] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clock);
    #1;
    n_cmp++; if (s_addr[0] !== 18'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", s_addr[0]); end
    n_cmp++; if (s_wdata[0] !== 16'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", s_wdata[0]); end
    n_cmp++; if (s_we_n[0] !== 1'b1) begin n_err++; $display("FAIL reset_we_n: got %b want 1", s_we_n[0]); end
    n_cmp++; if (s_done[0] !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", s_done[0]); end
    @(negedge Clock); Resetn = 1'b1;
    $display("reset: checked outputs held at reset values");
  endtask

  task automatic test_group4(input string name, input logic [15:0] w [6], input logic [15:0] ey,
                             input logic [15:0] ey2, input logic [15:0] eu, input logic [15:0] ev);
    int          cyc;
    logic [17:0] pa;
    logic [33:0] exp_log [4];
    for (int i = 0; i < 6; i++) rmem[RGB_B + 18'(i)] = w[i];
    exp_log[0] = {18'd0, ey};
    exp_log[1] = {18'd1, ey2};
    exp_log[2] = {U_B, eu};
    exp_log[3] = {V_B, ev};
    run_enc(0, -100, -1, cyc, pa);
    n_cmp++; if (cyc !== 25) begin n_err++; $display("FAIL %s_done_cycle: got %0d want 25", name, cyc); end
    n_cmp++; if (wr_cnt !== 4) begin n_err++; $display("FAIL %s_writes: got %0d want 4", name, wr_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wlog[i] !== exp_log[i]) begin
        n_err++;
        $display("FAIL %s_write%0d: got addr %0d data %h want addr %0d data %h",
                 name, i, wlog[i][33:16], wlog[i][15:0], exp_log[i][33:16], exp_log[i][15:0]);
      end
    end
    @(posedge Clock); #1;
    n_cmp++; if (s_done[0] !== 1'b0) begin n_err++; $display("FAIL %s_done_width: got %b want 0", name, s_done[0]); end
    $display("%s: Y %h %h U %h V %h done at cycle %0d", name, wlog[0][15:0], wlog[1][15:0], wlog[2][15:0], wlog[3][15:0], cyc);
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [17:0] pa;
    logic [33:0] exp_log [8];
    for (int i = 0; i < 12; i++) rmem[RGB_B + 18'(i)] = (i < 6) ? 16'h0000 : 16'hFFFF;
    exp_log = '{{18'd0, 16'h1010}, {18'd1, 16'h1010}, {U_B, 16'h8080}, {V_B, 16'h8080},
                {18'd2, 16'hEBEB}, {18'd3, 16'hEBEB}, {U_B + 18'd1, 16'h8080}, {V_B + 18'd1, 16'h8080}};
    run_enc(1, 5, 24, cyc, pa);
    n_cmp++; if (cyc !== 49) begin n_err++; $display("FAIL two_group_done_cycle: got %0d want 49", cyc); end
    n_cmp++; if (pa !== RGB_B + 18'd6) begin n_err++; $display("FAIL group1_read_addr: got %0d want %0d", pa, RGB_B + 18'd6); end
    n_cmp++; if (wr_cnt !== 8) begin n_err++; $display("FAIL two_group_writes: got %0d want 8", wr_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wlog[i] !== exp_log[i]) begin
        n_err++;
        $display("FAIL two_group_write%0d: got addr %0d data %h want addr %0d data %h",
                 i, wlog[i][33:16], wlog[i][15:0], exp_log[i][33:16], exp_log[i][15:0]);
      end
    end
    $display("back_to_back: 8 writes, group 1 read base %0d, done at cycle %0d", pa, cyc);
  endtask

  task automatic test_reset_in_write();
    int          cyc;
    logic [17:0] pa;
    bit          seen;
    seen = 1'b0;
    @(negedge Clock); log_clr = 1'b1;
    @(negedge Clock); log_clr = 1'b0; en[1] = 1'b1;
    @(posedge Clock); #1; en[1] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (s_we_n[1] === 1'b0) begin seen = 1'b1; break; end
      @(posedge Clock); #1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL write_phase_reached: got %b want 1", seen); end
    Resetn = 1'b0;
    #1;
    n_cmp++; if (s_we_n[1] !== 1'b1) begin n_err++; $display("FAIL abort_we_n: got %b want 1", s_we_n[1]); end
    n_cmp++; if (s_done[1] !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", s_done[1]); end
    @(posedge Clock); #1;
    n_cmp++; if (wr_cnt !== 0) begin n_err++; $display("FAIL abort_no_write: got %0d want 0", wr_cnt); end
    @(negedge Clock); Resetn = 1'b1;
    run_enc(1, -100, 0, cyc, pa);
    n_cmp++; if (pa !== RGB_B) begin n_err++; $display("FAIL restart_addr: got %0d want %0d", pa, RGB_B); end
    n_cmp++; if (cyc !== 49) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 49", cyc); end
    n_cmp++; if (wr_cnt !== 8) begin n_err++; $display("FAIL restart_writes: got %0d want 8", wr_cnt); end
    $display("reset_in_write: aborted, restart read base %0d, done at cycle %0d", pa, cyc);
  endtask

  task automatic test_random();
    int          cyc;
    logic [17:0] pa;
    logic [15:0] words [96];
    logic [15:0] w0, w1, w2;
    int          r, g, b, base, u01, u23, v01, v23;
    logic [7:0]  y [4];
    logic [7:0]  u [4];
    logic [7:0]  v [4];
    logic [33:0] exp_e [4];
    for (int i = 0; i < 96; i++) begin
      words[i] = 16'($urandom_range(0, 65535));
      rmem[RGB_B + 18'(i)] = words[i];
    end
    run_enc(2, -100, -1, cyc, pa);
    n_cmp++; if (cyc !== 385) begin n_err++; $display("FAIL random_done_cycle: got %0d want 385", cyc); end
    n_cmp++; if (wr_cnt !== 64) begin n_err++; $display("FAIL random_writes: got %0d want 64", wr_cnt); end
    for (int gg = 0; gg < 16; gg++) begin
      for (int p = 0; p < 4; p++) begin
        base = 6 * gg + 3 * (p / 2);
        w0 = words[base]; w1 = words[base + 1]; w2 = words[base + 2];
        if (p % 2 == 0) begin r = int'(w0[15:8]); g = int'(w0[7:0]);  b = int'(w1[15:8]); end
        else            begin r = int'(w1[7:0]);  g = int'(w2[15:8]); b = int'(w2[7:0]);  end
        y[p] = ref_conv(r, g, b, 0);
        u[p] = ref_conv(r, g, b, 1);
        v[p] = ref_conv(r, g, b, 2);
      end
      u01 = (int'(u[0]) + int'(u[1]) + 1) / 2; u23 = (int'(u[2]) + int'(u[3]) + 1) / 2;
      v01 = (int'(v[0]) + int'(v[1]) + 1) / 2; v23 = (int'(v[2]) + int'(v[3]) + 1) / 2;
      exp_e[0] = {18'(2 * gg), y[0], y[1]};
      exp_e[1] = {18'(2 * gg + 1), y[2], y[3]};
      exp_e[2] = {U_B + 18'(gg), u01[7:0], u23[7:0]};
      exp_e[3] = {V_B + 18'(gg), v01[7:0], v23[7:0]};
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (wlog[4 * gg + k] !== exp_e[k]) begin
          n_err++;
          $display("FAIL random_g%0d_w%0d: got addr %0d data %h want addr %0d data %h", gg, k,
                   wlog[4 * gg + k][33:16], wlog[4 * gg + k][15:0], exp_e[k][33:16], exp_e[k][15:0]);
        end
      end
    end
    $display("random: 64 pixels, %0d writes, done at cycle %0d", wr_cnt, cyc);
  endtask

  initial begin
    logic [15:0] w [6];
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    test_reset();
    w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    test_group4("black", w, 16'h1010, 16'h1010, 16'h8080, 16'h8080);
    w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    test_group4("white", w, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
    w = '{16'hFF00, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000};
    test_group4("red_black", w, 16'h5210, 16'h5210, 16'h6D6D, 16'hB8B8);
    test_back_to_back();
    test_reset_in_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
